climate_setpoint_ctrl: RTL



---
 rtl/climate_setpoint_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/climate_setpoint_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | climate_setpoint_ctrl                                                    |
// | Setpoint holder, hysteresis heat/cool FSM with dwell, stale-data flag,  |
// | display page select. Optional cooling path: define CLIMATE_COOL_EN.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module climate_setpoint_ctrl #(
   parameter int DATA_W      = 8,
   parameter int SET_MIN     = 16,
   parameter int SET_MAX     = 30,
   parameter int SET_DEFAULT = 24,
   parameter int HYST        = 1,
   parameter int MIN_DWELL   = 100_000_000,
   parameter int ROT_TICKS   = 50_000_000,
   parameter int STALE_TICKS = 200_000_000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] temp_i,
   input  logic [DATA_W-1:0] hum_i,
   input  logic              sample_valid_i,
   input  logic              mode_i,
   input  logic              set_up_i,
   input  logic              set_dn_i,
   output logic [DATA_W-1:0] setpoint_o,
   output logic [1:0]        disp_sel_o,
   output logic [DATA_W-1:0] disp_val_o,
   output logic              heat_o,
   output logic              cool_o,
   output logic              match_o,
   output logic              stale_o
);

   localparam int c_dwell_w = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
   localparam int c_rot_w   = (ROT_TICKS > 1) ? $clog2(ROT_TICKS) : 1;
   localparam int c_stale_w = (STALE_TICKS > 1) ? $clog2(STALE_TICKS) : 1;

   localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(MIN_DWELL - 1);
   localparam logic [c_rot_w-1:0]   c_rot_last   = c_rot_w'(ROT_TICKS - 1);
   localparam logic [c_stale_w-1:0] c_stale_last = c_stale_w'(STALE_TICKS - 1);
   localparam logic [DATA_W-1:0]    c_set_min    = DATA_W'(SET_MIN);
   localparam logic [DATA_W-1:0]    c_set_max    = DATA_W'(SET_MAX);
   localparam logic [DATA_W-1:0]    c_set_dflt   = DATA_W'(SET_DEFAULT);
   localparam logic [DATA_W:0]      c_hyst       = (DATA_W + 1)'(HYST);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_HEAT = 2'd2,
      ST_COOL = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_W-1:0]     r_temp_q;
   logic [DATA_W-1:0]     r_hum_q;
   logic                  r_have_sample;
   logic [c_stale_w-1:0]  r_stale_cnt;
   logic                  r_stale;
   logic [DATA_W-1:0]     r_setpoint;
   logic [c_dwell_w-1:0]  r_dwell_cnt;
   logic                  r_heat;
   logic                  r_match;
   logic [c_rot_w-1:0]    r_rot_cnt;
   logic                  r_page;
   logic [1:0]            r_disp_sel;
   logic [DATA_W-1:0]     r_disp_val;

   logic [DATA_W:0]       w_temp_ext;
   logic [DATA_W:0]       w_set_ext;
   logic [DATA_W:0]       w_set_lo;
   logic                  w_dwell_ok;

   // Sample capture and staleness; the counter parks at its last value so
   // stale stays asserted until the next strobe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_temp_q      <= '0;
         r_hum_q       <= '0;
         r_have_sample <= 1'b0;
         r_stale_cnt   <= '0;
         r_stale       <= 1'b1;
      end else if (sample_valid_i) begin
         r_temp_q      <= temp_i;
         r_hum_q       <= hum_i;
         r_have_sample <= 1'b1;
         r_stale_cnt   <= '0;
         r_stale       <= 1'b0;
      end else if (r_stale_cnt == c_stale_last) begin
         r_stale       <= 1'b1;
         r_have_sample <= 1'b0;
      end else begin
         r_stale_cnt   <= r_stale_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_setpoint <= c_set_dflt;
      end else if (mode_i && set_up_i && !set_dn_i && (r_setpoint < c_set_max)) begin
         r_setpoint <= r_setpoint + 1'b1;
      end else if (mode_i && set_dn_i && !set_up_i && (r_setpoint > c_set_min)) begin
         r_setpoint <= r_setpoint - 1'b1;
      end
   end

   // One extra bit so setpoint+HYST cannot wrap and setpoint-HYST clamps at 0.
   assign w_temp_ext = {1'b0, r_temp_q};
   assign w_set_ext  = {1'b0, r_setpoint};
   assign w_set_lo   = (w_set_ext >= c_hyst) ? (w_set_ext - c_hyst) : '0;
   assign w_dwell_ok = (r_dwell_cnt >= c_dwell_last);

`ifdef CLIMATE_COOL_EN
   logic [DATA_W:0] w_set_hi;
   assign w_set_hi = w_set_ext + c_hyst;
`endif

   always_comb begin
      w_state_nxt = r_state;
      if (!r_have_sample) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
               if (w_dwell_ok && (w_temp_ext < w_set_lo)) begin
                  w_state_nxt = ST_HEAT;
`ifdef CLIMATE_COOL_EN
               end else if (w_dwell_ok && (w_temp_ext > w_set_hi)) begin
                  w_state_nxt = ST_COOL;
`endif
               end
            end
            ST_HEAT: begin
               if (w_dwell_ok && (w_temp_ext >= w_set_ext)) w_state_nxt = ST_HOLD;
            end
`ifdef CLIMATE_COOL_EN
            ST_COOL: begin
               if (w_dwell_ok && (w_temp_ext <= w_set_ext)) w_state_nxt = ST_HOLD;
            end
`endif
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_dwell_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state) begin
            r_dwell_cnt <= '0;
         end else if (!w_dwell_ok) begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_heat  <= 1'b0;
         r_match <= 1'b0;
      end else begin
         r_heat  <= (r_state == ST_HEAT);
         r_match <= r_have_sample && (r_temp_q == r_setpoint);
      end
   end

`ifdef CLIMATE_COOL_EN
   logic r_cool;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_cool <= 1'b0;
      else         r_cool <= (r_state == ST_COOL);
   end
   assign cool_o = r_cool;
`else
   assign cool_o = 1'b0;
`endif

   // Rotation is held at page 0 while editing so read mode always resumes on TEMP.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rot_cnt <= '0;
         r_page    <= 1'b0;
      end else if (mode_i) begin
         r_rot_cnt <= '0;
         r_page    <= 1'b0;
      end else if (r_rot_cnt == c_rot_last) begin
         r_rot_cnt <= '0;
         r_page    <= ~r_page;
      end else begin
         r_rot_cnt <= r_rot_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_disp_sel <= 2'd3;
         r_disp_val <= '0;
      end else if (r_stale) begin
         r_disp_sel <= 2'd3;
         r_disp_val <= '0;
      end else if (mode_i) begin
         r_disp_sel <= 2'd2;
         r_disp_val <= r_setpoint;
      end else if (r_page) begin
         r_disp_sel <= 2'd1;
         r_disp_val <= r_hum_q;
      end else begin
         r_disp_sel <= 2'd0;
         r_disp_val <= r_temp_q;
      end
   end

   assign setpoint_o = r_setpoint;
   assign disp_sel_o = r_disp_sel;
   assign disp_val_o = r_disp_val;
   assign heat_o     = r_heat;
   assign match_o    = r_match;
   assign stale_o    = r_stale;

endmodule
`default_nettype wire
